pipelined_cla_adder: RTL

- Parametrised, pipelined carry-lookahead add/subtract unit for the convolution datapath (MAC accumulate path).
- Operand width is split into SEG-bit segments. Each segment uses internal generate/propagate lookahead carry logic.
- One segment resolves per pipeline stage, with carry registered between stages.
- Valid/ready handshake with backpressure, full throughput (one op per cycle), and signed-overflow flag.

---
 rtl/pipelined_cla_adder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Pipelined add/subtract unit for the MAC accumulate path. The operand is
//   split into SEG-bit segments. Pipeline stage k resolves segment k with
//   generate/propagate lookahead logic, then registers the carry for stage k+1.
//   Latency is STAGES = WIDTH/SEG cycles. Throughput is one beat per cycle.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake (in_ready = out_ready | ~out_valid)
//   a, b, cin, sub       operands; sub=1 computes a-b (cin ignored)
//   out_valid/out_ready  output handshake; the whole pipe stalls on backpressure
//   sum, cout, ovf       result, carry out of MSB, signed overflow
//   gate_act             per-stage {P,G,carry-in} activity, stage 0 in the LSBs

// One segment of lookahead logic. c[i] is the carry into bit i.
module cla_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic [SEG-1:0] p,
    output logic [SEG-1:0] g,
    output logic [SEG-1:0] c,
    output logic           co
);
    logic [SEG:0] cc;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        cc    = '0;
        cc[0] = ci;
        for (int i = 0; i < SEG; i++) cc[i+1] = g[i] | (p[i] & cc[i]);
    end

    assign c  = cc[SEG-1:0];
    assign s  = p ^ c;
    assign co = cc[SEG];
endmodule

module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic               sub,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   sum,
    output logic               cout,
    output logic               ovf,
    output logic [3*WIDTH-1:0] gate_act
);
    localparam int STAGES = WIDTH / SEG;

    logic adv;

    // Stage k registers hold the operands that entered stage k, so stage k+1
    // can read its own segment from them. The sum bits resolved so far travel
    // with the beat, and every stage carries its own valid bit.
    logic [STAGES-1:0]                 vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0]      a_q, b_q, s_q;
    logic [STAGES-1:0]                 c_q;
    logic [STAGES-1:0][3*SEG-1:0]      ga_q;
    logic                              ovf_q;

    // Inputs to each stage's logic
    logic [STAGES-1:0][WIDTH-1:0]      a_src, b_src, s_src;
    logic [STAGES-1:0]                 c_src, v_src;

    // Outputs of each segment
    logic [STAGES-1:0][SEG-1:0]        seg_s, seg_p, seg_g, seg_c;
    logic [STAGES-1:0]                 seg_co;

    // Next-state values for the stage registers
    logic [STAGES-1:0][WIDTH-1:0]      s_nxt;
    logic [STAGES-1:0][3*SEG-1:0]      ga_nxt;
    logic                              ovf_nxt;

    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    // Stage 0 takes its inputs from the ports and folds subtraction into the
    // operands. Later stages take their inputs from the previous register.
    always_comb begin
        a_src[0] = a;
        b_src[0] = sub ? ~b : b;
        c_src[0] = sub | cin;
        s_src[0] = '0;
        v_src[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            a_src[k] = a_q[k-1];
            b_src[k] = b_q[k-1];
            c_src[k] = c_q[k-1];
            s_src[k] = s_q[k-1];
            v_src[k] = vld_pipe[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_seg #(.SEG(SEG)) u_seg (
            .a  (a_src[k][k*SEG +: SEG]),
            .b  (b_src[k][k*SEG +: SEG]),
            .ci (c_src[k]),
            .s  (seg_s[k]),
            .p  (seg_p[k]),
            .g  (seg_g[k]),
            .c  (seg_c[k]),
            .co (seg_co[k])
        );
    end

    // Splice each newly resolved segment into the sum that travels with the
    // beat. Gate activity is forced to zero for bubbles.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            s_nxt[k]                = s_src[k];
            s_nxt[k][k*SEG +: SEG]  = seg_s[k];
            ga_nxt[k]               = v_src[k] ? {seg_p[k], seg_g[k], seg_c[k]} : '0;
        end
        ovf_nxt = seg_c[STAGES-1][SEG-1] ^ seg_co[STAGES-1];
    end

    // The pipe moves as a whole. Bubbles are kept, which makes the hold
    // behaviour trivially lossless.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            c_q      <= '0;
            ga_q     <= '0;
            ovf_q    <= 1'b0;
        end else if (adv) begin
            vld_pipe <= v_src;
            a_q      <= a_src;
            b_q      <= b_src;
            s_q      <= s_nxt;
            c_q      <= seg_co;
            ga_q     <= ga_nxt;
            ovf_q    <= ovf_nxt;
        end
    end

    assign out_valid = vld_pipe[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;
    assign gate_act  = ga_q;

    // The final stage has no consumer for its operand copy.
    logic unused_ops;
    assign unused_ops = ^{a_q[STAGES-1], b_q[STAGES-1]};
endmodule
